// File: rtl/mips_datapath_register_multiport.sv
// Multi-port MIPS register file: N read ports, two prioritised write ports,
// optional write-to-read bypass and a pending-write scoreboard for decode.
package mips_datapath_register_multiport_pkg;
    typedef struct packed {
        logic clk;
        logic rst_n;
    } Data_Control_Control_T;
endpackage

module mips_datapath_register_multiport
    import mips_datapath_register_multiport_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDR_BITS   = 5,
    parameter int READ_PORTS  = 2,
    parameter int PASSTHROUGH = 0,
    parameter int ZERO_REG    = 1
) (
    input  Data_Control_Control_T           ctrl,
    input  logic [READ_PORTS*ADDR_BITS-1:0] rdAddr,
    input  logic [READ_PORTS-1:0]           rdUse,
    output logic [READ_PORTS*WIDTH-1:0]     rdData,
    output logic [READ_PORTS-1:0]           rdBusy,
    output logic                            stall,
    input  logic                            wrEn0,
    input  logic [ADDR_BITS-1:0]            wrAddr0,
    input  logic [WIDTH-1:0]                wrData0,
    input  logic                            wrEn1,
    input  logic [ADDR_BITS-1:0]            wrAddr1,
    input  logic [WIDTH-1:0]                wrData1,
    input  logic                            resEn,
    input  logic [ADDR_BITS-1:0]            resAddr,
    output logic                            portEq
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic clk;
    logic rst_n;
    assign clk   = ctrl.clk;
    assign rst_n = ctrl.rst_n;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Accesses to the hardwired zero register are dropped up front
    logic we0;
    logic we1;
    logic res;
    assign we0 = wrEn0 & ~((ZERO_REG != 0) && (wrAddr0 == '0));
    assign we1 = wrEn1 & ~((ZERO_REG != 0) && (wrAddr1 == '0));
    assign res = resEn & ~((ZERO_REG != 0) && (resAddr == '0));

    always_comb begin
        busy_d = busy_q;
        if (we0) busy_d[wrAddr0] = 1'b0;
        if (we1) busy_d[wrAddr1] = 1'b0;
        // A newly issued producer supersedes the write retiring now
        if (res) busy_d[resAddr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (we0) mem_q[wrAddr0] <= wrData0;
            if (we1) mem_q[wrAddr1] <= wrData1;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDR_BITS-1:0] a;
        logic [WIDTH-1:0]     d;
        logic                 hit;

        assign a = rdAddr[p*ADDR_BITS +: ADDR_BITS];

        always_comb begin
            d   = mem_q[a];
            hit = 1'b0;
            if (PASSTHROUGH != 0) begin
                if (we1 && (wrAddr1 == a)) begin
                    d   = wrData1;
                    hit = 1'b1;
                end else if (we0 && (wrAddr0 == a)) begin
                    d   = wrData0;
                    hit = 1'b1;
                end
            end
            if ((ZERO_REG != 0) && (a == '0)) d = '0;
        end

        assign rdData[p*WIDTH +: WIDTH] = d;
        assign rdBusy[p] = busy_q[a] & ~hit;
    end

    assign stall = |(rdUse & rdBusy);

    if (READ_PORTS > 1) begin : g_eq
        assign portEq = ~rst_n |
            (rdData[0 +: WIDTH] == rdData[WIDTH +: WIDTH]);
    end else begin : g_no_eq
        assign portEq = 1'b0;
    end

endmodule

// File: tb/tb_mips_datapath_register_multiport.sv
// Directed bench: runs bypass and non-bypass register files side by side
// on identical stimulus with hand-computed expectations.
module tb_mips_datapath_register_multiport;
    import mips_datapath_register_multiport_pkg::*;

    logic clk;
    logic rst_n;
    Data_Control_Control_T ctrl;
    assign ctrl = '{clk: clk, rst_n: rst_n};

    logic [4:0]  rdA0, rdA1;
    logic [9:0]  rdAddr;
    logic [1:0]  rdUse;
    logic        wrEn0, wrEn1, resEn;
    logic [4:0]  wrAddr0, wrAddr1, resAddr;
    logic [31:0] wrData0, wrData1;
    assign rdAddr = {rdA1, rdA0};

    logic [63:0] pt_data, np_data;
    logic [1:0]  pt_busy, np_busy;
    logic        pt_stall, np_stall, pt_eq, np_eq;

    mips_datapath_register_multiport #(.PASSTHROUGH(1)) dut_pt (
        .ctrl(ctrl), .rdAddr(rdAddr), .rdUse(rdUse),
        .rdData(pt_data), .rdBusy(pt_busy), .stall(pt_stall),
        .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
        .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
        .resEn(resEn), .resAddr(resAddr), .portEq(pt_eq)
    );

    mips_datapath_register_multiport #(.PASSTHROUGH(0)) dut_np (
        .ctrl(ctrl), .rdAddr(rdAddr), .rdUse(rdUse),
        .rdData(np_data), .rdBusy(np_busy), .stall(np_stall),
        .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
        .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
        .resEn(resEn), .resAddr(resAddr), .portEq(np_eq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic quiet();
        wrEn0 = 0; wrEn1 = 0; resEn = 0; rdUse = 2'b00;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; rdA0 = 0; rdA1 = 0; rdUse = 0;
        wrEn0 = 0; wrAddr0 = 0; wrData0 = 0;
        wrEn1 = 0; wrAddr1 = 0; wrData1 = 0;
        resEn = 0; resAddr = 0;
        #2;
        chk("rst_data_pt", pt_data[31:0], 32'h0);
        chk("rst_data_np", np_data[31:0], 32'h0);
        chk("rst_busy", {30'd0, np_busy}, 32'h0);
        chk("rst_stall", {31'd0, np_stall}, 32'h0);
        chk("rst_eq", {31'd0, pt_eq}, 32'h1);
        #10 rst_n = 1;

        // dual-write collision on r7
        edge_step();
        wrEn0 = 1; wrAddr0 = 7; wrData0 = 32'h11111111;
        wrEn1 = 1; wrAddr1 = 7; wrData1 = 32'h22222222;
        rdA0 = 7;
        #1;
        chk("coll_byp_pt", pt_data[31:0], 32'h22222222);
        chk("coll_old_np", np_data[31:0], 32'h0);
        edge_step();
        quiet();
        #1;
        chk("coll_np", np_data[31:0], 32'h22222222);
        chk("coll_pt", pt_data[31:0], 32'h22222222);

        // bypass of r9
        edge_step();
        wrEn0 = 1; wrAddr0 = 9; wrData0 = 32'hCAFEF00D;
        rdA0 = 9;
        #1;
        chk("byp_pt", pt_data[31:0], 32'hCAFEF00D);
        chk("byp_old_np", np_data[31:0], 32'h0);
        edge_step();
        quiet();
        #1;
        chk("byp_next_np", np_data[31:0], 32'hCAFEF00D);

        // port compare
        rdA0 = 7; rdA1 = 9;
        #1;
        chk("eq_diff", {31'd0, np_eq}, 32'h0);
        chk("rd1_r9", np_data[63:32], 32'hCAFEF00D);
        rdA1 = 7;
        #1;
        chk("eq_same", {31'd0, np_eq}, 32'h1);

        // scoreboard hazard on r3
        edge_step();
        resEn = 1; resAddr = 3; rdA0 = 3;
        #1;
        chk("res_c0_pt", {30'd0, pt_busy}, 32'h0);
        chk("res_c0_np", {30'd0, np_busy}, 32'h0);
        edge_step();
        quiet(); rdUse = 2'b01;
        #1;
        chk("haz_c1_pt", {31'd0, pt_stall}, 32'h1);
        chk("haz_c1_np", {31'd0, np_stall}, 32'h1);
        edge_step();
        #1;
        chk("haz_c2_pt", {31'd0, pt_stall}, 32'h1);
        chk("haz_c2_np", {31'd0, np_stall}, 32'h1);
        edge_step();
        wrEn0 = 1; wrAddr0 = 3; wrData0 = 32'h33;
        #1;
        chk("haz_c3_pt", {31'd0, pt_stall}, 32'h0);
        chk("haz_c3_np", {31'd0, np_stall}, 32'h1);
        chk("haz_c3_dat", pt_data[31:0], 32'h33);
        edge_step();
        wrEn0 = 0;
        #1;
        chk("haz_c4_pt", {31'd0, pt_stall}, 32'h0);
        chk("haz_c4_np", {31'd0, np_stall}, 32'h0);
        rdUse = 2'b00;

        // set vs clear race on r4
        edge_step();
        wrEn0 = 1; wrAddr0 = 4; wrData0 = 32'h44;
        resEn = 1; resAddr = 4; rdA0 = 4;
        edge_step();
        quiet();
        #1;
        chk("race_busy_pt", {31'd0, pt_busy[0]}, 32'h1);
        chk("race_busy_np", {31'd0, np_busy[0]}, 32'h1);
        chk("race_dat", np_data[31:0], 32'h44);
        wrEn1 = 1; wrAddr1 = 4; wrData1 = 32'h45;
        #1;
        chk("clr_now_pt", {31'd0, pt_busy[0]}, 32'h0);
        chk("clr_now_np", {31'd0, np_busy[0]}, 32'h1);
        edge_step();
        quiet();
        #1;
        chk("clr_next_np", {31'd0, np_busy[0]}, 32'h0);
        chk("clr_dat", np_data[31:0], 32'h45);

        // zero register
        edge_step();
        wrEn0 = 1; wrAddr0 = 0; wrData0 = 32'hFFFFFFFF;
        resEn = 1; resAddr = 0; rdA0 = 0; rdA1 = 0;
        #1;
        chk("zero_byp_pt", pt_data[31:0], 32'h0);
        edge_step();
        quiet(); rdUse = 2'b11;
        #1;
        chk("zero_dat_np", np_data[31:0], 32'h0);
        chk("zero_busy_pt", {30'd0, pt_busy}, 32'h0);
        chk("zero_busy_np", {30'd0, np_busy}, 32'h0);
        chk("zero_stall", {31'd0, np_stall}, 32'h0);
        chk("zero_eq", {31'd0, pt_eq}, 32'h1);
        rdUse = 2'b00;

        // asynchronous reset mid-cycle
        edge_step();
        wrEn0 = 1; wrAddr0 = 5; wrData0 = 32'hDEADBEEF;
        resEn = 1; resAddr = 6;
        edge_step();
        quiet();
        rdA0 = 5; rdA1 = 6; rdUse = 2'b10;
        #1;
        chk("pre_rst_dat", np_data[31:0], 32'hDEADBEEF);
        chk("pre_rst_stall", {31'd0, np_stall}, 32'h1);
        #1 rst_n = 0;
        #1;
        chk("arst_dat_pt", pt_data[31:0], 32'h0);
        chk("arst_dat_np", np_data[31:0], 32'h0);
        chk("arst_stall_pt", {31'd0, pt_stall}, 32'h0);
        chk("arst_stall_np", {31'd0, np_stall}, 32'h0);
        chk("arst_eq", {31'd0, np_eq}, 32'h1);

        // writes during reset are dropped
        wrEn0 = 1; wrAddr0 = 8; wrData0 = 32'h88;
        edge_step();
        quiet();
        rst_n = 1;
        rdA0 = 8; rdA1 = 7;
        #1;
        chk("rst_wr_drop", np_data[31:0], 32'h0);
        chk("rst_r7_gone", np_data[63:32], 32'h0);
        edge_step();
        #1;
        chk("post_rst_r8", np_data[31:0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/mips_datapath_register_multiport.md
# mips_datapath_register_multiport

Parametrised successor to the single-write, two-read MIPS register datapath. Provides a configurable register file with `READ_PORTS` read ports and two prioritised write ports, optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard. The scoreboard lets the pipelined decode stage detect read-after-write hazards and stall. It sits in decode: read ports feed the ID/EX latch, write ports are driven by writeback (port 0) and an early-result path (port 1, e.g. link/multiply).

## Interface

Parameters:
- `WIDTH`, 32, data word width in bits.
- `ADDR_BITS`, 5, register address width; depth = 2^ADDR_BITS.
- `READ_PORTS`, 2, number of read ports, 1..4.
- `PASSTHROUGH`, 0, 1 = write data bypasses to same-cycle reads of the same address.
- `ZERO_REG`, 1, 1 = register 0 reads 0, ignores writes and never becomes busy.

Ports:
- `ctrl`  input  `Data_Control_Control_T`  bundle carrying clock (rising edge) and reset. Reset is asynchronous and active-low.
- `rdAddr`  input  READ_PORTS*ADDR_BITS  read addresses; port i is at bits [i*ADDR_BITS +: ADDR_BITS].
- `rdUse`  input  READ_PORTS  port i's operand is consumed this cycle (used for stall only).
- `rdData`  output  READ_PORTS*WIDTH  read data, packed like `rdAddr`.
- `rdBusy`  output  READ_PORTS  port i's register has an unresolved pending write.
- `stall`  output  1  OR over i of (`rdUse[i]` & `rdBusy[i]`).
- `wrEn0`, `wrAddr0`, `wrData0`  input  1/ADDR_BITS/WIDTH  write port 0 (writeback).
- `wrEn1`, `wrAddr1`, `wrData1`  input  1/ADDR_BITS/WIDTH  write port 1 (early result).
- `resEn`, `resAddr`  input  1/ADDR_BITS  reserve: mark a register pending for an issued producer.
- `portEq`  output  1  `rdData` port 0 equals port 1; tied 0 when READ_PORTS = 1.

## Operation

- Storage: 2^ADDR_BITS × WIDTH flops. Written on the rising clock edge.
- Write priority: when both write ports are enabled with the same address, port 1 wins. No data merge.
- Zero register: with ZERO_REG = 1, writes and reserves to address 0 are dropped, and reads of address 0 return 0 regardless of bypass.
- Read path, combinational per port:
  - PASSTHROUGH = 1: if `wrEn1` and address matches, return `wrData1`; else if `wrEn0` and address matches, return `wrData0`; else return storage.
  - PASSTHROUGH = 0: return storage only. A same-cycle write becomes visible the next cycle.
- Scoreboard: one busy bit per register, updated at the clock edge.
  - Set: `resEn` sets busy[`resAddr`].
  - Clear: any enabled write clears busy[`wrAddr`].
  - Set and clear on the same address in the same cycle: set wins, since the new producer supersedes the old one.
  - Reserving an already busy register keeps it busy; no counting.
- `rdBusy[i]` = busy[`rdAddr[i]`] & ~(PASSTHROUGH & an enabled write matching `rdAddr[i]` this cycle). With PASSTHROUGH = 0, a clearing write still shows busy that cycle.
- `stall` is combinational and does not gate writes or reserves. The instantiating stage holds its own state.

## Timing

- Reset (ctrl reset low, asynchronous):
  - Effect is immediate and needs no clock: all registers become 0 and all busy bits become 0.
  - Outputs under reset: `rdData` reads 0 unless bypassed, `rdBusy` = 0, `stall` = 0, `portEq` = 1.
  - While reset is held, writes and reserves are ignored.
  - Deassertion takes effect at the next rising edge, with no synchronisation inside the block.
- Reset mid-operation discards all pending busy bits and register contents.
- Write-to-read latency: 0 cycles with PASSTHROUGH = 1, 1 cycle with PASSTHROUGH = 0.
- Reserve-to-busy latency: 1 cycle; a reservation is not visible in the cycle it is issued.
- Write-to-busy-clear latency: 0 cycles with PASSTHROUGH = 1, 1 cycle otherwise.
- No handshakes; every input is sampled every cycle.

## Test plan

- Reset: write 0xDEADBEEF to r5, then pulse reset low mid-cycle. Immediately, before any clock edge, reading r5 returns 0 and `stall` = 0.
- Dual-write collision: in one cycle set `wrEn0`/`wrEn1` with r7 = 0x11111111 and r7 = 0x22222222. Next cycle r7 reads 0x22222222.
- Bypass: PASSTHROUGH = 1, write r9 = 0xCAFEF00D and read r9 in the same cycle. `rdData` = 0xCAFEF00D. With PASSTHROUGH = 0, the same stimulus returns the old value, and returns 0xCAFEF00D the next cycle.
- Scoreboard hazard:
  - Stimulus: `resEn` r3 in cycle 0; read r3 with `rdUse` = 1 in cycles 1–3; write r3 in cycle 3.
  - Required with PASSTHROUGH = 1: `stall` = 1 in cycles 1–2 and 0 in cycle 3.
  - Required with PASSTHROUGH = 0: `stall` = 1 through cycle 3 and 0 in cycle 4.
- Set-versus-clear race: in one cycle, write r4 and reserve r4. r4 remains busy next cycle. A later write of r4 clears it.
- Zero register: write r0 = 0xFFFFFFFF and reserve r0. r0 reads 0, `rdBusy` = 0, and `portEq` = 1 when both ports read r0.
